reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file, the successor to the single-cycle core's 2R/1W register file.
- Adds configurable read and write port counts, same-cycle write-to-read bypass, a hardwired-zero r0 option, and a per-register busy scoreboard.
- The scoreboard lets a future pipelined or multi-issue core detect RAW hazards.
- Sits between decode (read/alloc) and writeback (write).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, >=2).
- AW, $clog2(NREGS), address width (derived; not to be overridden).
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2).
- BYPASS, 1, 1 = write data forwarded combinationally to same-cycle reads; 0 = read returns old value.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- rd_addr  in  NUM_RD*AW  packed read addresses; port i at [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data, combinational.
- rd_busy  out  NUM_RD  busy bit of each addressed register, combinational.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  packed write addresses.
- wr_data  in  NUM_WR*XLEN  packed write data.
- alloc_en  in  1  mark alloc_addr busy (destination issued, result pending).
- alloc_addr  in  AW  register to mark busy.
- busy_vec  out  NREGS  full scoreboard, bit r = register r busy.

Behaviour:
- Reset (reset==0, async): all NREGS registers := 0; all busy bits := 0. While in reset, rd_data = 0 and rd_busy = 0 on every port, and busy_vec = 0.
- Reads: purely combinational, zero latency; no clocked read path.
- Writes: on the rising clock edge with wr_en[j]=1, reg[wr_addr[j]] := wr_data[j].
- Write-write collision (NUM_WR=2, both enabled, same address): port 1 wins. Bypass follows the same priority.
- Bypass (BYPASS=1): if any enabled write port addresses rd_addr[i] in the current cycle, rd_data[i] returns that wr_data (highest-priority port). If BYPASS=0, rd_data[i] returns the stored value until the edge.
- ZERO_REG=1:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, including under bypass.
  - alloc to 0 is ignored; busy_vec[0] is constant 0.
- ZERO_REG=0: register 0 is an ordinary register.
- Scoreboard, per register r, at the clock edge:
  - alloc_en && alloc_addr==r: busy[r] := 1. Allocation has priority over a same-cycle write clear, because the new producer supersedes the old.
  - Otherwise, any wr_en[j] && wr_addr[j]==r: busy[r] := 0.
  - Otherwise busy[r] holds.
  - Alloc of an already-busy register keeps it busy (no error).
  - A write to a non-busy register leaves it non-busy.
- rd_busy[i] reflects the registered busy bit of rd_addr[i]. With BYPASS=1, a same-cycle write to rd_addr[i] without a same-cycle alloc to it forces rd_busy[i]=0, so the consumer can take the bypassed value.
- Width: addresses are exactly AW bits, so no out-of-range check is needed when NREGS = 2^AW. Data is stored unmodified with no extension.
- Reset asserted mid-operation: contents and scoreboard clear immediately; in-flight writes in that cycle are lost.

Decomposition:
- Shared package/include `rf_pkg`:
  - Default XLEN, NREGS and AW constants.
  - Macros/functions for packed-port slicing: `RF_SLICE(bus,i,w)`.
  - Write-port priority resolver function (returns hit flag, data, and port index for an address).
- One natural sub-module: `rf_scoreboard` (busy-bit array with alloc/clear priority and async active-low reset, NREGS-wide).
- Storage array, write logic and bypass mux stay in `reg_file_mp`.

Test Plan:
- Reset: drive reset=0 for 2 cycles with wr_en=1 to r5 -> all rd_data=0, busy_vec=0. Release and read r5 -> 0.
- Basic write/read (defaults): write 30 to r1, then read ports (r0,r1) -> (0,30). Write 20 to r0, then read r0 -> 0.
- Bypass: same cycle, wr r3=0xDEADBEEF and read r3 -> rd_data=0xDEADBEEF before the edge. Rebuild with BYPASS=0 -> old value 0 before the edge, 0xDEADBEEF after.
- Dual write collision (NUM_WR=2): both ports write r7, port0=11 and port1=22 -> read r7 = 22 after the edge; the bypassed read in the same cycle also = 22.
- Scoreboard:
  - alloc r4 -> busy_vec[4]=1 next cycle and rd_busy=1 when read.
  - Write r4=9 -> busy clears after the edge; the same-cycle read shows rd_busy=0, rd_data=9.
  - Simultaneous alloc r4 + write r4 -> busy stays 1.
  - alloc r0 -> busy_vec[0]=0.
- Async reset mid-run: with r2=5 and busy[2]=1, pulse reset low between clock edges -> rd_data for r2 and busy_vec go to 0 immediately without a clock edge.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// packed-port slicing helper and the write-port priority resolver.

`define RF_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_AW    = $clog2(RF_NREGS);

    // Resolver operates on padded vectors so one function serves every
    // configuration: up to 2 write ports and up to 256 registers.
    localparam int RF_MAX_WR = 2;
    localparam int RF_MAX_AW = 8;
    localparam int RF_PORT_W = $clog2(RF_MAX_WR);

    typedef struct packed {
        logic                 hit;
        logic [RF_PORT_W-1:0] port;
    } rf_fwd_t;

    // Finds the enabled write port that targets rd_addr. Ports are scanned
    // in ascending order so the highest-numbered matching port wins.
    function automatic rf_fwd_t rf_wr_resolve(
        input logic [RF_MAX_WR-1:0]           en,
        input logic [RF_MAX_WR*RF_MAX_AW-1:0] addr,
        input logic [RF_MAX_AW-1:0]           rd_addr
    );
        rf_fwd_t res;
        res = '0;
        for (int j = 0; j < RF_MAX_WR; j++) begin
            if (en[j] && (addr[j*RF_MAX_AW +: RF_MAX_AW] == rd_addr)) begin
                res.hit  = 1'b1;
                res.port = RF_PORT_W'(j);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set by
// allocation of a pending result and cleared by its writeback.

module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = RF_NREGS,
    parameter int AW       = $clog2(NREGS),
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    output logic [NREGS-1:0]     busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy state: a new allocation supersedes a same-cycle writeback.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            logic alloc_hit;
            logic wr_hit;
            alloc_hit = alloc_en && (int'(alloc_addr) == r);
            wr_hit    = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (int'(`RF_SLICE(wr_addr, j, AW)) == r)) begin
                    wr_hit = 1'b1;
                end
            end
            if (alloc_hit) begin
                busy_d[r] = 1'b1;
            end else if (wr_hit) begin
                busy_d[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // Busy register, cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port integer register file with combinational reads,
// same-cycle write bypass, optional hardwired-zero r0 and a busy scoreboard
// for RAW hazard detection between decode and writeback.

module reg_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int AW       = $clog2(NREGS),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic                   alloc_en,
    input  logic [AW-1:0]          alloc_addr,
    output logic [NREGS-1:0]       busy_vec
);

    logic [XLEN-1:0]                mem [NREGS];
    logic [RF_MAX_WR-1:0]           wr_en_pad;
    logic [RF_MAX_WR*RF_MAX_AW-1:0] wr_addr_pad;

    // Widen the write-port bundle to the resolver's fixed shape.
    always_comb begin
        wr_en_pad   = '0;
        wr_addr_pad = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_en_pad[j]                      = wr_en[j];
            wr_addr_pad[j*RF_MAX_AW +: AW]    = `RF_SLICE(wr_addr, j, AW);
        end
    end

    // Storage: later write ports overwrite earlier ones on an address clash;
    // writes to r0 are dropped when it is hardwired to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] &&
                    !((ZERO_REG != 0) && (`RF_SLICE(wr_addr, j, AW) == '0))) begin
                    mem[`RF_SLICE(wr_addr, j, AW)] <= `RF_SLICE(wr_data, j, XLEN);
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy_vec   (busy_vec)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]        addr;
        logic [RF_MAX_AW-1:0] addr_pad;
        rf_fwd_t              fwd;
        logic [XLEN-1:0]      fwd_data;
        logic                 zero_hit;
        logic                 alloc_hit;
        logic [XLEN-1:0]      data_out;
        logic                 busy_out;

        assign addr      = `RF_SLICE(rd_addr, i, AW);
        assign zero_hit  = (ZERO_REG != 0) && (addr == '0);
        assign alloc_hit = alloc_en && (alloc_addr == addr);

        // Widen the read address for the resolver.
        always_comb begin
            addr_pad         = '0;
            addr_pad[AW-1:0] = addr;
        end

        assign fwd = rf_wr_resolve(wr_en_pad, wr_addr_pad, addr_pad);

        // Pick the data of the winning write port.
        always_comb begin
            fwd_data = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (int'(fwd.port) == j) begin
                    fwd_data = `RF_SLICE(wr_data, j, XLEN);
                end
            end
        end

        // Read mux: reset and r0 force zero, then bypass, then storage.
        // A bypassed write retires the pending result unless a new producer
        // is allocated to the same register this cycle.
        always_comb begin
            data_out = mem[addr];
            busy_out = busy_vec[addr];
            if (!reset) begin
                data_out = '0;
                busy_out = 1'b0;
            end else begin
                if (zero_hit) begin
                    data_out = '0;
                end else if ((BYPASS != 0) && fwd.hit) begin
                    data_out = fwd_data;
                end
                if ((BYPASS != 0) && fwd.hit && !alloc_hit) begin
                    busy_out = 1'b0;
                end
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data_out;
        assign rd_busy[i]              = busy_out;
    end

endmodule
